trinity_mem_bank: RTL and testbench

Parametrised successor to the 8-entry tile memory, driven by the same 8-bit control bus.
- Generalised in data width and depth, with a dedicated address port.
- Adds a read-only mode and a multi-cycle clear sweep, with busy and out_valid handshake outputs.
- Sits beside the compute tiles as a scratch register bank; data_out feeds the next tile's data_in.

---
 rtl/trinity_mem_pkg.sv | 19 +
 rtl/trinity_mem_parity.sv | 18 +
 rtl/trinity_mem_bank.sv | 138 +++++++++++++
 tb/tb_trinity_mem_bank.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/trinity_mem_pkg.sv
// Shared constants for the trinity scratch memory bank: control-bus layout,
// command modes and FSM state encoding.
package trinity_mem_pkg;

    localparam int BUS_VALID_BIT = 7;
    localparam int BUS_EXEC_BIT  = 2;
    localparam int BUS_MODE_LSB  = 0;

    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_READ  = 2'd1;
    localparam logic [1:0] MODE_SWAP  = 2'd2;
    localparam logic [1:0] MODE_CLEAR = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/trinity_mem_parity.sv
// Even-parity generate for a written word and check for a stored word.
// Only instantiated when TRINITY_MEM_PARITY_EN is defined.
module trinity_mem_parity
    import trinity_mem_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic              i_rd_par,
    output logic              o_wr_par,
    output logic              o_err
);

    assign o_wr_par = ^i_wr_data;
    assign o_err    = (^i_rd_data) != i_rd_par;

endmodule

// File: rtl/trinity_mem_bank.sv
// Scratch register bank with PASS/READ/SWAP commands and a multi-cycle CLEAR sweep.
// Optional per-entry parity protection is enabled by defining TRINITY_MEM_PARITY_EN.
module trinity_mem_bank
    import trinity_mem_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [7:0]        bus_in,
    input  logic [AW-1:0]     addr_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              busy,
    output logic              par_err
);

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    state_t            r_state;
    logic [AW-1:0]     r_ptr;
    logic [DATA_W-1:0] r_data_out;
    logic              r_out_valid;

    logic              w_accept;
    logic [1:0]        w_mode;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_unused_rsvd;

    assign w_mode        = bus_in[BUS_MODE_LSB +: 2];
    assign w_accept      = bus_in[BUS_VALID_BIT] && bus_in[BUS_EXEC_BIT] && (r_state == ST_IDLE);
    assign w_rd_word     = r_mem[addr_in];
    assign w_unused_rsvd = &{1'b0, bus_in[6:3]};

    assign busy      = (r_state == ST_CLEAR);
    assign data_out  = r_data_out;
    assign out_valid = r_out_valid;

    // The sweep owns the write port while busy, so SWAP cannot collide with it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_mem[r_ptr] <= '0;
        end else if (w_accept && (w_mode == MODE_SWAP)) begin
            r_mem[addr_in] <= data_in;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (w_mode)
                            MODE_PASS: begin
                                r_data_out  <= data_in;
                                r_out_valid <= 1'b1;
                            end
                            MODE_READ, MODE_SWAP: begin
                                r_data_out  <= w_rd_word;
                                r_out_valid <= 1'b1;
                            end
                            default: begin
                                r_state <= ST_CLEAR;
                                r_ptr   <= '0;
                            end
                        endcase
                    end
                end
                ST_CLEAR: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == LAST_PTR) begin
                        r_state     <= ST_IDLE;
                        r_ptr       <= '0;
                        r_data_out  <= '0;
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

`ifdef TRINITY_MEM_PARITY_EN
    logic r_par [DEPTH];
    logic r_par_err;
    logic w_wr_par;
    logic w_par_mismatch;

    trinity_mem_parity #(
        .DATA_W (DATA_W)
    ) u_parity (
        .i_wr_data (data_in),
        .i_rd_data (w_rd_word),
        .i_rd_par  (r_par[addr_in]),
        .o_wr_par  (w_wr_par),
        .o_err     (w_par_mismatch)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_par[i] <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            r_par[r_ptr] <= 1'b0;
        end else if (w_accept && (w_mode == MODE_SWAP)) begin
            r_par[addr_in] <= w_wr_par;
        end
    end

    // Sticky until reset; the data is still returned on a mismatch.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_par_err <= 1'b0;
        end else if (w_accept && ((w_mode == MODE_READ) || (w_mode == MODE_SWAP)) && w_par_mismatch) begin
            r_par_err <= 1'b1;
        end
    end

    assign par_err = r_par_err;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_trinity_mem_bank.sv
// Directed, table-driven bench for trinity_mem_bank (DATA_W=8, DEPTH=8).
module tb_trinity_mem_bank;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [7:0] bus_in;
    logic [2:0] addr_in;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       out_valid;
    logic       busy;
    logic       par_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] bus;
        logic [2:0] addr;
        logic [7:0] data;
        logic       exp_ov;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[$];

    trinity_mem_bank #(
        .DATA_W (8),
        .DEPTH  (8)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus_in    (bus_in),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .data_out  (data_out),
        .out_valid (out_valid),
        .busy      (busy),
        .par_err   (par_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] b, input logic [2:0] a, input logic [7:0] d);
        bus_in  = b;
        addr_in = a;
        data_in = d;
    endtask

    task automatic apply_reset();
        sys_rst_n = 1'b0;
        drive(8'h00, 3'd0, 8'h00);
        step();
        step();
        #2;
        sys_rst_n = 1'b1;
        step();
    endtask

    initial begin : main
        int bcnt;
        bit done;

        // Bus encodings: 0x84 PASS, 0x85 READ, 0x86 SWAP, 0x87 CLEAR (valid+exec).
        for (int i = 0; i < 8; i++) vecs.push_back('{8'h85, 3'(i), 8'h00, 1'b1, 8'h00});
        vecs.push_back('{8'h86, 3'd3, 8'hA5, 1'b1, 8'h00});
        vecs.push_back('{8'h86, 3'd3, 8'h5A, 1'b1, 8'hA5});
        vecs.push_back('{8'h85, 3'd3, 8'h00, 1'b1, 8'h5A});
        vecs.push_back('{8'h80, 3'd0, 8'h3C, 1'b0, 8'h5A});
        vecs.push_back('{8'h04, 3'd0, 8'h3C, 1'b0, 8'h5A});
        vecs.push_back('{8'h84, 3'd0, 8'h3C, 1'b1, 8'h3C});
        vecs.push_back('{8'h00, 3'd0, 8'h00, 1'b0, 8'h3C});
        vecs.push_back('{8'hFD, 3'd3, 8'h00, 1'b1, 8'h5A});
        vecs.push_back('{8'h86, 3'd1, 8'h12, 1'b1, 8'h00});
        vecs.push_back('{8'h86, 3'd1, 8'h34, 1'b1, 8'h12});

        sys_rst_n = 1'b0;
        drive(8'h00, 3'd0, 8'h00);
        #2;
        chk("rst_dout", data_out, 8'h00);
        chk("rst_ov", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_par", par_err, 1'b0);
        apply_reset();

        foreach (vecs[i]) begin
            drive(vecs[i].bus, vecs[i].addr, vecs[i].data);
            step();
            chk($sformatf("vec%0d_ov", i), out_valid, vecs[i].exp_ov);
            chk($sformatf("vec%0d_dout", i), data_out, vecs[i].exp_dout);
            chk($sformatf("vec%0d_busy", i), busy, 1'b0);
            chk($sformatf("vec%0d_par", i), par_err, 1'b0);
        end

        // Fill with 0xFF; old contents: addr1=0x34, addr3=0x5A, others 0.
        for (int i = 0; i < 8; i++) begin
            drive(8'h86, 3'(i), 8'hFF);
            step();
            chk($sformatf("fill%0d_dout", i), data_out, (i == 1) ? 8'h34 : (i == 3) ? 8'h5A : 8'h00);
        end
        drive(8'h84, 3'd0, 8'h77);
        step();
        chk("pass77", data_out, 8'h77);

        // CLEAR, with a SWAP held on the bus throughout the sweep.
        drive(8'h87, 3'd0, 8'h00);
        step();
        chk("clr_accept_ov", out_valid, 1'b0);
        drive(8'h86, 3'd2, 8'h11);
        bcnt = 0;
        done = 1'b0;
        if (busy) bcnt = 1;
        for (int c = 0; c < 20 && !done; c++) begin
            if (!busy) begin
                done = 1'b1;
            end else begin
                chk("sweep_ov", out_valid, 1'b0);
                chk("sweep_dout", data_out, 8'h77);
                step();
                if (busy) bcnt++;
            end
        end
        chk("sweep_done", done, 1'b1);
        chk("busy_cycles", bcnt, 8);
        chk("sweep_end_ov", out_valid, 1'b1);
        chk("sweep_end_dout", data_out, 8'h00);
        step();
        chk("post_swap_ov", out_valid, 1'b1);
        chk("post_swap_dout", data_out, 8'h00);
        chk("post_swap_busy", busy, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(8'h85, 3'(i), 8'h00);
            step();
            chk($sformatf("postclr_rd%0d", i), data_out, (i == 2) ? 8'h11 : 8'h00);
        end

        // Asynchronous reset mid-sweep at ptr=4.
        for (int i = 0; i < 8; i++) begin
            drive(8'h86, 3'(i), 8'hC3);
            step();
        end
        drive(8'h84, 3'd0, 8'h99);
        step();
        drive(8'h87, 3'd0, 8'h00);
        step();
        drive(8'h00, 3'd0, 8'h00);
        for (int i = 0; i < 4; i++) step();
        chk("mid_busy", busy, 1'b1);
        chk("mid_dout", data_out, 8'h99);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_ov", out_valid, 1'b0);
        chk("arst_dout", data_out, 8'h00);
        #2;
        sys_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(8'h85, 3'(i), 8'h00);
            step();
            chk($sformatf("arst_rd%0d_ov", i), out_valid, 1'b1);
            chk($sformatf("arst_rd%0d", i), data_out, 8'h00);
        end

`ifdef TRINITY_MEM_PARITY_EN
        drive(8'h86, 3'd5, 8'h0F);
        step();
        chk("par_clean", par_err, 1'b0);
        drive(8'h00, 3'd0, 8'h00);
        step();
        dut.r_mem[5][0] = ~dut.r_mem[5][0];
        drive(8'h85, 3'd5, 8'h00);
        step();
        chk("par_rd_dout", data_out, 8'h0E);
        chk("par_set", par_err, 1'b1);
        drive(8'h85, 3'd4, 8'h00);
        step();
        chk("par_sticky", par_err, 1'b1);
        apply_reset();
        chk("par_rst", par_err, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
